// File: rtl/hazard_stall_unit.sv
// Stall-side hazard control beside the ID stage: inserts one bubble per load-use hazard
// and freezes the whole pipeline while a cache miss is serviced through a req/ready handshake.
module hazard_stall_unit #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WR_out,
  input  logic             I_miss,
  input  logic             D_miss,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Flush,
  output logic             Pipe_Stall,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             miss_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    FILL  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_miss_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_set_err;
  logic              w_lu;
  logic              w_pcwrite;
  logic              w_ifid_write;
  logic              w_flush;
  logic              w_stall;
  logic              w_req;
  logic              w_sel;

  assign w_lu = EX_MemRead && (EX_WR_out != 5'd0) &&
                ((EX_WR_out == ID_Rs) || (ID_UsesRt && (EX_WR_out == ID_Rt)));

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    w_set_err    = 1'b0;
    w_pcwrite    = 1'b1;
    w_ifid_write = 1'b1;
    w_flush      = 1'b0;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    w_sel        = 1'b0;
    case (r_state)
      IDLE: begin
        if (D_miss || I_miss) begin
          // A miss freezes rather than bubbles, so it masks any concurrent load-use hazard.
          w_pcwrite    = 1'b0;
          w_ifid_write = 1'b0;
          w_stall      = 1'b1;
          w_wait_next  = '0;
          w_state_next = D_miss ? DWAIT : IWAIT;
        end else if (w_lu) begin
          w_pcwrite    = 1'b0;
          w_ifid_write = 1'b0;
          w_flush      = 1'b1;
        end
      end
      DWAIT, IWAIT: begin
        w_pcwrite    = 1'b0;
        w_ifid_write = 1'b0;
        w_stall      = 1'b1;
        w_req        = 1'b1;
        w_sel        = (r_state == DWAIT);
        if (mem_ready) begin
          w_state_next = FILL;
        end else if (r_wait_cnt != WAIT_MAX) begin
          w_wait_next = r_wait_cnt + 1'b1;
          w_set_err   = (r_wait_cnt == WAIT_LAST);
        end
      end
      FILL: begin
        w_pcwrite    = 1'b0;
        w_ifid_write = 1'b0;
        w_stall      = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_miss_err  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_set_err) begin
        r_miss_err <= 1'b1;
      end
      if (!w_pcwrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // Reset forces a bubble into ID/EX and drops any outstanding request at once.
  assign PCWrite     = ~rst & w_pcwrite;
  assign IF_ID_Write = ~rst & w_ifid_write;
  assign ID_EX_Flush = rst | w_flush;
  assign Pipe_Stall  = ~rst & w_stall;
  assign mem_req     = ~rst & w_req;
  assign mem_sel     = ~rst & w_sel;
  assign miss_err    = r_miss_err;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios plus randomized cycles, all checked
// against a behavioural model of the bubble/freeze/miss-service rules.
module tb_hazard_stall_unit;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       ID_Rs = '0;
  logic [4:0]       ID_Rt = '0;
  logic             ID_UsesRt = 1'b0;
  logic             EX_MemRead = 1'b0;
  logic [4:0]       EX_WR_out = '0;
  logic             I_miss = 1'b0;
  logic             D_miss = 1'b0;
  logic             mem_ready = 1'b0;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             ID_EX_Flush;
  logic             Pipe_Stall;
  logic             mem_req;
  logic             mem_sel;
  logic             miss_err;
  logic [CNT_W-1:0] stall_cnt;

  hazard_stall_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WR_out(EX_WR_out),
    .I_miss(I_miss), .D_miss(D_miss), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Flush(ID_EX_Flush),
    .Pipe_Stall(Pipe_Stall), .mem_req(mem_req), .mem_sel(mem_sel),
    .miss_err(miss_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: which miss is being serviced (none / 'D' / 'I'), whether the fill cycle is due,
  // how long the current request has waited, the sticky error and the stalled-cycle count.
  byte m_serving  = 0;
  bit  m_filling  = 0;
  int  m_waited   = 0;
  bit  m_err      = 0;
  int  m_stalls   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_serving = 0;
    m_filling = 0;
    m_waited  = 0;
    m_err     = 0;
    m_stalls  = 0;
  endtask

  // One clock of stimulus: drive after the falling edge, check outputs, then advance the model at the rising edge.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input bit uses_rt,
                      input bit ld, input logic [4:0] wr, input bit im, input bit dm, input bit rdy);
    bit hazard, frozen, bubble;
    @(negedge clk);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRt = uses_rt; EX_MemRead = ld; EX_WR_out = wr;
    I_miss = im; D_miss = dm; mem_ready = rdy;
    #1;
    hazard = ld && (wr != 0) && (wr == rs || (uses_rt && wr == rt));
    frozen = m_filling || (m_serving != 0) || dm || im;
    bubble = !frozen && hazard;
    check_eq("PCWrite",     PCWrite,     !(frozen || bubble));
    check_eq("IF_ID_Write", IF_ID_Write, !(frozen || bubble));
    check_eq("ID_EX_Flush", ID_EX_Flush, bubble);
    check_eq("Pipe_Stall",  Pipe_Stall,  frozen);
    check_eq("mem_req",     mem_req,     m_serving != 0);
    check_eq("mem_sel",     mem_sel,     m_serving == "D");
    check_eq("miss_err",    miss_err,    m_err);
    check_eq("stall_cnt",   stall_cnt,   m_stalls);
    $display("cyc %0d rs=%0d rt=%0d ut=%0d ld=%0d wr=%0d im=%0d dm=%0d rdy=%0d -> pc=%0d fl=%0d st=%0d req=%0d sel=%0d err=%0d cnt=%0d",
             cyc, rs, rt, uses_rt, ld, wr, im, dm, rdy, PCWrite, ID_EX_Flush, Pipe_Stall,
             mem_req, mem_sel, miss_err, stall_cnt);
    @(posedge clk);
    cyc++;
    if (frozen || bubble) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
    if (m_filling) begin
      m_filling = 0;
    end else if (m_serving != 0) begin
      if (rdy) begin
        m_serving = 0;
        m_filling = 1;
      end else begin
        if (m_waited < MAX_WAIT) m_waited++;
        if (m_waited == MAX_WAIT) m_err = 1;
      end
    end else if (dm) begin
      m_serving = "D";
      m_waited  = 0;
    end else if (im) begin
      m_serving = "I";
      m_waited  = 0;
    end
  endtask

  task automatic idle_step(input bit rdy);
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, rdy);
  endtask

  // Reset asserted between edges; its effect on outputs must be immediate.
  task automatic do_reset();
    @(negedge clk);
    I_miss = 1'b0; D_miss = 1'b0; mem_ready = 1'b0; EX_MemRead = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_PCWrite",   PCWrite,     0);
    check_eq("rst_IF_ID",     IF_ID_Write, 0);
    check_eq("rst_Flush",     ID_EX_Flush, 1);
    check_eq("rst_Stall",     Pipe_Stall,  0);
    check_eq("rst_mem_req",   mem_req,     0);
    check_eq("rst_mem_sel",   mem_sel,     0);
    check_eq("rst_stall_cnt", stall_cnt,   0);
    check_eq("rst_miss_err",  miss_err,    0);
    $display("cyc %0d reset asserted", cyc);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Load-use on rs: exactly one bubble, then the pipeline flows.
    step(5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    idle_step(1'b0);
    check_eq("lu_stall_cnt", stall_cnt, 1);

    // r0 never stalls; rt match ignored when rt is not a source.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step(5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    check_eq("no_stall_cnt", stall_cnt, 1);

    // D-miss serviced with ready on the third wait cycle; D_miss held through FILL is ignored there.
    do_reset();
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle_step(1'b1);
    check_eq("dmiss_stall_cnt", stall_cnt, 5);

    // Simultaneous D and I miss with a concurrent load-use hazard: D first, then I, no bubble.
    do_reset();
    for (int k = 0; k < 6; k++)
      step(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, k < 4, k < 1, k == 1 || k == 4);
    idle_step(1'b0);
    check_eq("dual_stall_cnt", stall_cnt, 6);

    // No ready: miss_err sets after MAX_WAIT wait cycles and stays set through completion.
    do_reset();
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < MAX_WAIT + 2; k++) idle_step(1'b0);
    check_eq("err_set", miss_err, 1);
    idle_step(1'b1);
    idle_step(1'b0);
    idle_step(1'b0);
    check_eq("err_sticky", miss_err, 1);

    // Reset mid-wait drops the request; a later ready is ignored.
    do_reset();
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle_step(1'b0);
    do_reset();
    idle_step(1'b1);
    idle_step(1'b0);

    // Counter saturates at all-ones.
    for (int k = 0; k < 20; k++) step(5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_saturate", stall_cnt, CNT_MAX);

    // Randomized traffic on a small register range so hazards collide often.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall-side counterpart to the pipeline's forwarding unit. Forwarding resolves data hazards by bypassing; this block resolves the hazards that bypassing cannot.
- Handles two cases: load-use hazards, by inserting a bubble, and I-/D-cache misses, by freezing the whole pipeline while it runs a request/ready handshake with the memory back-end.
- Sits beside the ID stage. It drives the PC, IF/ID and ID/EX write/flush controls, the memory request, and a saturating stall-cycle counter.

Parameters:
- MAX_WAIT, 64, maximum cycles a miss may wait for mem_ready before the miss error flag sets.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ID_Rs  input  5  rs field of the instruction in ID.
- ID_Rt  input  5  rt field of the instruction in ID.
- ID_UsesRt  input  1  ID instruction reads rt as a source.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_WR_out  input  5  destination register of the instruction in EX.
- I_miss  input  1  I-cache miss for the current fetch (level).
- D_miss  input  1  D-cache miss for the current MEM access (level).
- mem_ready  input  1  back-end has completed the line transfer (one-cycle pulse).
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register write enable.
- ID_EX_Flush  output  1  load a bubble into ID/EX.
- Pipe_Stall  output  1  freeze EX/MEM and MEM/WB.
- mem_req  output  1  line-fill request to the back-end.
- mem_sel  output  1  request source: 1 = D-cache, 0 = I-cache.
- miss_err  output  1  sticky; a miss waited longer than MAX_WAIT.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- States: IDLE, DWAIT, IWAIT, FILL.
- Reset, asynchronous, any state:
  - State goes to IDLE; wait_cnt, stall_cnt and miss_err go to 0.
  - While rst is high: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, Pipe_Stall=0, mem_req=0, mem_sel=0.
  - Reset during DWAIT/IWAIT drops mem_req immediately. A mem_ready arriving after reset is ignored.
- Load-use hazard (lu) = EX_MemRead && EX_WR_out!=0 && (EX_WR_out==ID_Rs || (ID_UsesRt && EX_WR_out==ID_Rt)).
  - Register 0 never causes a stall.
- IDLE outputs are combinational, same cycle:
  - D_miss or I_miss: PCWrite=0, IF_ID_Write=0, Pipe_Stall=1, ID_EX_Flush=0. This is a freeze, not a bubble; miss overrides lu.
  - Else lu: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, Pipe_Stall=0. Exactly one bubble per hazard; next cycle lu is false because the load has moved to MEM.
  - Else: PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0, Pipe_Stall=0.
  - mem_req=0.
- IDLE transitions:
  - D_miss goes to DWAIT; D has priority when D_miss and I_miss are both high.
  - Else I_miss goes to IWAIT.
  - wait_cnt clears on entry to either wait state.
- DWAIT / IWAIT:
  - Outputs: mem_req=1; mem_sel=1 in DWAIT, 0 in IWAIT; full freeze (PCWrite=0, IF_ID_Write=0, Pipe_Stall=1, ID_EX_Flush=0).
  - mem_ready sampled high goes to FILL. mem_req deasserts in FILL.
  - Otherwise wait_cnt increments, saturating.
  - When wait_cnt reaches MAX_WAIT, miss_err sets and stays set until reset. The state keeps waiting.
- FILL:
  - One cycle: full freeze, mem_req=0. The cache writes the line in this cycle.
  - Goes to IDLE unconditionally; D_miss/I_miss are ignored in FILL.
  - A miss still pending in IDLE, e.g. the I-miss queued behind a D-miss, starts a new request then.
- Minimum miss penalty: request cycle plus FILL cycle, i.e. 2 frozen cycles beyond the IDLE detect cycle when mem_ready is high on the first DWAIT cycle.
- mem_ready while in IDLE or FILL is ignored.
- stall_cnt increments on every non-reset cycle where PCWrite=0. It saturates at all-ones and never wraps.

Test Plan:
- lw $8 in EX (EX_MemRead=1, EX_WR_out=8), ID_Rs=8 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle all enables 1; stall_cnt=1.
- EX_WR_out=0 with ID_Rs=0, and separately ID_Rt match with ID_UsesRt=0 -> no stall, stall_cnt unchanged.
- D_miss high in IDLE, mem_ready pulsed on the 3rd DWAIT cycle -> mem_req=1, mem_sel=1 for 3 cycles, then 1 FILL cycle, IDLE; Pipe_Stall=1 and ID_EX_Flush=0 throughout; stall_cnt=5, including the detect cycle.
- D_miss and I_miss together, mem_ready after 1 cycle each -> DWAIT (mem_sel=1), FILL, IDLE (detect), IWAIT (mem_sel=0), FILL, IDLE; lu asserted at the same time produces no bubble.
- MAX_WAIT=4, D_miss with no mem_ready -> miss_err rises after 4 wait cycles and stays set; a later mem_ready completes FILL normally.
- rst asserted mid-DWAIT -> mem_req=0 and state IDLE immediately; a mem_ready after rst release is ignored; stall_cnt=0 and miss_err=0; CNT_W=4 bench saturates stall_cnt at 15.
